// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round controller.
// The FSM state encoding is defined here so that the controller and any
// future sibling blocks agree on it.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_KEY_REQ = 3'd1,
        ST_ARK     = 3'd2,
        ST_SUB     = 3'd3,
        ST_SHIFT   = 3'd4,
        ST_MIX     = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERR     = 3'd7
    } aes_round_state_e;

    localparam int AES128_NUM_ROUNDS = 10;
    localparam int AES256_NUM_ROUNDS = 14;

    // States in which the controller waits on an external handshake.
    function automatic logic is_wait_state(input aes_round_state_e st);
        return (st == ST_KEY_REQ) || (st == ST_SUB) || (st == ST_MIX);
    endfunction

endpackage

// File: rtl/aes_wait_timer.sv
// Watchdog counter for the handshake wait states. Clears on state entry,
// counts while enabled, and flags expiry on the LIMIT-th enabled cycle.
module aes_wait_timer #(
    parameter int LIMIT = 256
) (
    input  logic aes_clk,
    input  logic resetn,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    logic [15:0] count_q;

    // The first cycle after entry sees count 0, so the LIMIT-th cycle sees LIMIT-1.
    assign expire_o = enable_i && (count_q == 16'(LIMIT - 1));

    // Cycle counter; clear has priority so a new wait starts from zero.
    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + 16'd1;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES block-encryption round sequencer: walks KEY_REQ/ARK/SUB/SHIFT/MIX for
// each round and pulses done_o at the end. Optional watchdog on the wait
// states is enabled with the macro AES_ROUND_CTRL_TIMEOUT_EN.
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS     = AES128_NUM_ROUNDS,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       aes_clk,
    input  logic       resetn,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic [3:0] round_o,
    output logic       key_req_o,
    output logic [3:0] key_sel_o,
    input  logic       key_vld_i,
    output logic       sub_en_o,
    input  logic       sub_done_i,
    output logic       shift_en_o,
    output logic       mix_en_o,
    input  logic       mix_done_i,
    output logic       ark_en_o,
    output logic       done_o,
    output logic       err_o
);

    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

    // Refuse to elaborate with out-of-range configuration.
    if ((NUM_ROUNDS < 10) || (NUM_ROUNDS > 14) ||
        (TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_param_check
        $error("aes_round_ctrl: illegal NUM_ROUNDS or TIMEOUT_CYCLES");
    end

    aes_round_state_e state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic             wait_expire;

    logic busy_q, key_req_q, ark_q, sub_q, shift_q, mix_q, done_q;

`ifdef AES_ROUND_CTRL_TIMEOUT_EN
    logic err_q;

    aes_wait_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .aes_clk  (aes_clk),
        .resetn   (resetn),
        .clear_i  (state_d != state_q),
        .enable_i (is_wait_state(state_q)),
        .expire_o (wait_expire)
    );

    assign err_o = err_q;
`else
    assign wait_expire = 1'b0;
    assign err_o       = 1'b0;
`endif

    // Next-state and round-counter logic; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_KEY_REQ;
                    round_d = 4'd0;
                end
            end
            ST_KEY_REQ: begin
                if (key_vld_i)        state_d = ST_ARK;
                else if (wait_expire) state_d = ST_ERR;
            end
            ST_ARK: begin
                if (round_q == ROUND_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_SUB;
                    round_d = round_q + 4'd1;
                end
            end
            ST_SUB: begin
                if (sub_done_i)       state_d = ST_SHIFT;
                else if (wait_expire) state_d = ST_ERR;
            end
            ST_SHIFT: begin
                // The final round has no MixColumns step.
                state_d = (round_q < ROUND_LAST) ? ST_MIX : ST_KEY_REQ;
            end
            ST_MIX: begin
                if (mix_done_i)       state_d = ST_KEY_REQ;
                else if (wait_expire) state_d = ST_ERR;
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            round_d = 4'd0;
        end
    end

    // State, round and registered outputs decoded from the upcoming state.
    always_ff @(posedge aes_clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            round_q   <= 4'd0;
            busy_q    <= 1'b0;
            key_req_q <= 1'b0;
            ark_q     <= 1'b0;
            sub_q     <= 1'b0;
            shift_q   <= 1'b0;
            mix_q     <= 1'b0;
            done_q    <= 1'b0;
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            round_q   <= round_d;
            busy_q    <= (state_d != ST_IDLE);
            key_req_q <= (state_d == ST_KEY_REQ);
            ark_q     <= (state_d == ST_ARK);
            sub_q     <= (state_d == ST_SUB);
            shift_q   <= (state_d == ST_SHIFT);
            mix_q     <= (state_d == ST_MIX);
            done_q    <= (state_d == ST_DONE);
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
            err_q     <= (state_d == ST_ERR);
`endif
        end
    end

    assign busy_o     = busy_q;
    assign round_o    = round_q;
    assign key_sel_o  = round_q;
    assign key_req_o  = key_req_q;
    assign ark_en_o   = ark_q;
    assign sub_en_o   = sub_q;
    assign shift_en_o = shift_q;
    assign mix_en_o   = mix_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Testbench for aes_round_ctrl: scenario tasks with a key-index / done-edge
// scoreboard. Expected values are queued when a block is started and popped
// as the DUT produces key requests and done pulses.
module tb_aes_round_ctrl;

    logic       aes_clk = 1'b0;
    logic       resetn  = 1'b0;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic       key_vld_i  = 1'b1;
    logic       sub_done_i = 1'b1;
    logic       mix_done_i = 1'b1;
    logic       busy_o, key_req_o, sub_en_o, shift_en_o, mix_en_o, ark_en_o, done_o, err_o;
    logic [3:0] round_o, key_sel_o;

    int checks = 0;
    int errors = 0;

    int edge_cnt, ark_cnt, mix_cnt, done_cnt, err_cnt, done_edge, viol, kr4_len, unstable;
    int last_kr_rise;
    logic kr_prev, mix_prev;
    logic [3:0] kr_sel_prev;
    int key_delay_round = -1;
    int key_delay = 0;
    int kr_wait = 0;
    int obs_keys[$];
    int exp_keys[$];
    int exp_done[$];

    aes_round_ctrl #(
        .NUM_ROUNDS     (10),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .aes_clk    (aes_clk),
        .resetn     (resetn),
        .start_i    (start_i),
        .abort_i    (abort_i),
        .busy_o     (busy_o),
        .round_o    (round_o),
        .key_req_o  (key_req_o),
        .key_sel_o  (key_sel_o),
        .key_vld_i  (key_vld_i),
        .sub_en_o   (sub_en_o),
        .sub_done_i (sub_done_i),
        .shift_en_o (shift_en_o),
        .mix_en_o   (mix_en_o),
        .mix_done_i (mix_done_i),
        .ark_en_o   (ark_en_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    always #5 aes_clk = ~aes_clk;

    task automatic clear_stats();
        ark_cnt = 0; mix_cnt = 0; done_cnt = 0; err_cnt = 0; done_edge = -1;
        viol = 0; kr4_len = 0; unstable = 0; last_kr_rise = -1; kr_wait = 0;
        kr_prev = 1'b0; mix_prev = 1'b0; kr_sel_prev = 4'd0;
        obs_keys.delete(); exp_keys.delete(); exp_done.delete();
    endtask

    // Advance one clock, sample outputs 1ns after the edge and drive the key handshake.
    task automatic tick();
        int hot;
        @(posedge aes_clk);
        #1;
        edge_cnt++;
        if (key_req_o && !kr_prev) begin
            obs_keys.push_back(int'(key_sel_o));
            last_kr_rise = edge_cnt;
        end
        if (key_req_o && kr_prev && (key_sel_o != kr_sel_prev)) unstable++;
        if (key_req_o && key_sel_o == 4'd4) kr4_len++;
        if (ark_en_o) ark_cnt++;
        if (mix_en_o && !mix_prev) mix_cnt++;
        if (done_o) begin done_cnt++; done_edge = edge_cnt; end
        if (err_o) err_cnt++;
        hot = int'(key_req_o) + int'(ark_en_o) + int'(sub_en_o) + int'(shift_en_o) + int'(mix_en_o);
        if (hot > 1) viol++;
        kr_prev = key_req_o; mix_prev = mix_en_o; kr_sel_prev = key_sel_o;
        if (key_req_o && int'(key_sel_o) == key_delay_round && kr_wait < key_delay) begin
            key_vld_i = 1'b0;
            kr_wait++;
        end else begin
            key_vld_i = 1'b1;
        end
    endtask

    // Pulse start for one sampled edge; that edge is numbered 0.
    task automatic start_block();
        start_i  = 1'b1;
        edge_cnt = -1;
        tick();
        start_i  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick();
    endtask

    task automatic push_expected(input int done_at);
        for (int k = 0; k <= 10; k++) exp_keys.push_back(k);
        exp_done.push_back(done_at);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #3;
        checks++;
        if ({busy_o, key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o, done_o, err_o,
             round_o, key_sel_o} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {busy_o, key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o, done_o, err_o, round_o, key_sel_o});
        end
        repeat (2) @(posedge aes_clk);
        #2 resetn = 1'b1;
        clear_stats();
        edge_cnt = 0;
        tick();
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b required 0", busy_o);
        end
        $display("test_reset: outputs idle after reset");
    endtask

    task automatic test_full_block();
        int e, o;
        clear_stats();
        push_expected(51);
        start_block();
        wait_done(200);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL full_done_seen: got %0d done pulses required 1", done_cnt);
        end
        e = exp_done.pop_front();
        checks++;
        if (done_edge != e) begin
            errors++;
            $display("FAIL full_done_edge: got %0d required %0d", done_edge, e);
        end
        checks++;
        if (ark_cnt != 11) begin errors++; $display("FAIL full_ark_count: got %0d required 11", ark_cnt); end
        checks++;
        if (mix_cnt != 9) begin errors++; $display("FAIL full_mix_count: got %0d required 9", mix_cnt); end
        checks++;
        if (obs_keys.size() != exp_keys.size()) begin
            errors++;
            $display("FAIL full_key_count: got %0d required %0d", obs_keys.size(), exp_keys.size());
        end
        while (exp_keys.size() > 0 && obs_keys.size() > 0) begin
            e = exp_keys.pop_front();
            o = obs_keys.pop_front();
            checks++;
            if (o != e) begin errors++; $display("FAIL full_key_sel: got %0d required %0d", o, e); end
        end
        checks++;
        if (viol != 0) begin errors++; $display("FAIL full_onehot: %0d cycles with overlapping strobes, required 0", viol); end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL full_idle_after: busy got %b required 0", busy_o); end
        $display("test_full_block: done at edge %0d, ark %0d, mix %0d", done_edge, ark_cnt, mix_cnt);
    endtask

    task automatic test_key_delay();
        int e, o;
        clear_stats();
        key_delay_round = 4;
        key_delay = 3;
        push_expected(54);
        start_block();
        wait_done(200);
        e = exp_done.pop_front();
        checks++;
        if (done_edge != e) begin errors++; $display("FAIL delay_done_edge: got %0d required %0d", done_edge, e); end
        checks++;
        if (kr4_len != 4) begin errors++; $display("FAIL delay_keyreq_len: got %0d required 4", kr4_len); end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL delay_keysel_stable: %0d changes required 0", unstable); end
        while (exp_keys.size() > 0 && obs_keys.size() > 0) begin
            e = exp_keys.pop_front();
            o = obs_keys.pop_front();
            checks++;
            if (o != e) begin errors++; $display("FAIL delay_key_sel: got %0d required %0d", o, e); end
        end
        key_delay_round = -1;
        key_delay = 0;
        tick();
        $display("test_key_delay: round 4 key request held %0d cycles, done at edge %0d", kr4_len, done_edge);
    endtask

    task automatic test_abort();
        bit found = 0;
        clear_stats();
        start_block();
        for (int i = 0; i < 200 && !found; i++) begin
            if (mix_en_o && round_o == 4'd5) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL abort_reach_mix5: MIX of round 5 not reached"); end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if ({busy_o, key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o, done_o, round_o} !== 11'h0) begin
            errors++;
            $display("FAIL abort_idle: got %b required all zero",
                     {busy_o, key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o, done_o, round_o});
        end
        repeat (60) tick();
        checks++;
        if (done_cnt != 0) begin errors++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt); end
        $display("test_abort: aborted in MIX of round 5");
        clear_stats();
        push_expected(51);
        start_block();
        wait_done(200);
        checks++;
        if (done_edge != exp_done.pop_front()) begin
            errors++;
            $display("FAIL abort_rerun_done: got edge %0d required 51", done_edge);
        end
        checks++;
        if (ark_cnt != 11) begin errors++; $display("FAIL abort_rerun_ark: got %0d required 11", ark_cnt); end
        tick();
        $display("test_abort: following block done at edge %0d", done_edge);
    endtask

    task automatic test_timeout();
        bit found = 0;
        clear_stats();
        sub_done_i = 1'b0;
        start_block();
        for (int i = 0; i < 20 && !found; i++) begin
            if (sub_en_o) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL timeout_reach_sub: SUB not reached"); end
`ifdef AES_ROUND_CTRL_TIMEOUT_EN
        begin
            int sub_cycles = 1;
            bit left = 0;
            for (int i = 0; i < 50 && !left; i++) begin
                tick();
                if (sub_en_o) sub_cycles++;
                else left = 1;
            end
            checks++;
            if (sub_cycles != 8) begin errors++; $display("FAIL timeout_sub_cycles: got %0d required 8", sub_cycles); end
            checks++;
            if (err_o !== 1'b1) begin errors++; $display("FAIL timeout_err_pulse: got %b required 1", err_o); end
            tick();
            checks++;
            if (busy_o !== 1'b0 || err_o !== 1'b0) begin
                errors++;
                $display("FAIL timeout_idle: busy %b err %b required 0 0", busy_o, err_o);
            end
            $display("test_timeout: err after %0d SUB cycles", sub_cycles);
        end
`else
        repeat (300) tick();
        checks++;
        if (sub_en_o !== 1'b1 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL timeout_wait_forever: sub_en %b busy %b required 1 1", sub_en_o, busy_o);
        end
        checks++;
        if (err_cnt != 0) begin errors++; $display("FAIL timeout_no_err: got %0d err pulses required 0", err_cnt); end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL timeout_abort_idle: busy %b required 0", busy_o); end
        $display("test_timeout: SUB held for 300 cycles without watchdog");
`endif
        sub_done_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        clear_stats();
        start_block();
        for (int i = 0; i < 100 && !found; i++) begin
            if (round_o == 4'd7) found = 1;
            else tick();
        end
        checks++;
        if (!found) begin errors++; $display("FAIL rstmid_reach_round7: round 7 not reached"); end
        #2 resetn = 1'b0;
        #1;
        checks++;
        if ({busy_o, key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o, done_o, err_o,
             round_o, key_sel_o} !== 16'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got %b required all zero",
                     {busy_o, key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o, done_o, err_o, round_o, key_sel_o});
        end
        repeat (2) tick();
        resetn = 1'b1;
        repeat (80) tick();
        checks++;
        if (done_cnt != 0 || err_cnt != 0) begin
            errors++;
            $display("FAIL rstmid_no_done: done %0d err %0d required 0 0", done_cnt, err_cnt);
        end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy %b required 0", busy_o); end
        $display("test_reset_mid: reset in round 7 discarded block");
    endtask

    task automatic test_back_to_back();
        int first_done;
        clear_stats();
        exp_done.push_back(51);
        exp_done.push_back(104);
        start_i  = 1'b1;
        edge_cnt = -1;
        tick();
        wait_done(200);
        first_done = done_edge;
        checks++;
        if (first_done != exp_done.pop_front()) begin
            errors++;
            $display("FAIL b2b_first_done: got edge %0d required 51", first_done);
        end
        tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy %b required 0", busy_o); end
        tick();
        checks++;
        if (key_req_o !== 1'b1 || last_kr_rise != first_done + 2) begin
            errors++;
            $display("FAIL b2b_next_keyreq: key_req %b at edge %0d required 1 at %0d",
                     key_req_o, last_kr_rise, first_done + 2);
        end
        for (int i = 0; i < 200 && done_cnt < 2; i++) tick();
        start_i = 1'b0;
        checks++;
        if (done_cnt != 2 || done_edge != exp_done.pop_front()) begin
            errors++;
            $display("FAIL b2b_second_done: %0d pulses, last at edge %0d required 2 at 104", done_cnt, done_edge);
        end
        repeat (5) tick();
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL b2b_stop: busy %b required 0", busy_o); end
        $display("test_back_to_back: done at edges %0d and %0d", first_done, done_edge);
    endtask

    initial begin
        clear_stats();
        edge_cnt = 0;
        test_reset();
        test_full_block();
        test_key_delay();
        test_abort();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, number of AES rounds after the initial AddRoundKey; legal range 10..14.
REQ-002 Parameter TIMEOUT_CYCLES, default 256, watchdog limit in cycles per wait state; legal range 2..65535.
REQ-003 aes_clk  in  1  clock; all state changes on its rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 start_i  in  1  begin one block encryption; sampled in IDLE only.
REQ-006 abort_i  in  1  synchronous abort of the current block.
REQ-007 busy_o  out  1  high in every state except IDLE.
REQ-008 round_o  out  4  current round number.
REQ-009 key_req_o / key_sel_o / key_vld_i  out 1 / out 4 / in 1  round-key request, round-key index, key valid.
REQ-010 sub_en_o / sub_done_i  out 1 / in 1  SubBytes enable (level), SubBytes complete.
REQ-011 shift_en_o  out  1  ShiftRows strobe, one cycle.
REQ-012 mix_en_o / mix_done_i  out 1 / in 1  MixColumns enable (level), MixColumns complete.
REQ-013 ark_en_o  out  1  AddRoundKey strobe, one cycle.
REQ-014 done_o  out  1  block complete, one-cycle pulse.
REQ-015 err_o  out  1  watchdog expiry, one-cycle pulse.

Function
REQ-016 FSM states: IDLE, KEY_REQ, ARK, SUB, SHIFT, MIX, DONE, ERR.
REQ-017 IDLE -> KEY_REQ when start_i=1; round counter cleared to 0.
REQ-018 KEY_REQ: key_req_o=1, key_sel_o=round_o held stable; exit to ARK on the edge that samples key_vld_i=1.
REQ-019 ARK: ark_en_o=1 for exactly one cycle; exit to DONE if round=NUM_ROUNDS, else round increments by 1 and FSM enters SUB.
REQ-020 SUB: sub_en_o=1 held until sub_done_i=1 is sampled; then SHIFT.
REQ-021 SHIFT: shift_en_o=1 for one cycle; next state is MIX if round<NUM_ROUNDS, else KEY_REQ (final round skips MixColumns).
REQ-022 MIX: mix_en_o=1 held until mix_done_i=1 is sampled; then KEY_REQ.
REQ-023 DONE: done_o=1 for one cycle; then IDLE; start_i ignored in DONE.
REQ-024 Each state lasts at least one cycle; done/valid inputs are ignored outside their own wait state.
REQ-025 start_i ignored while busy_o=1; no queuing.
REQ-026 abort_i=1 in any non-IDLE state: next state IDLE, all strobes/enables low, round cleared, no done_o; abort_i wins over start_i in the same cycle.
REQ-027 With zero-wait handshakes and NUM_ROUNDS=10, done_o is high in the cycle following the 51st edge after the edge that samples start_i.
REQ-028 At most one of key_req_o, ark_en_o, sub_en_o, shift_en_o, mix_en_o is high in any cycle.

Reset
REQ-029 On resetn low: state IDLE; round_o, key_sel_o, and all 1-bit outputs are 0, asynchronously and immediately.
REQ-030 Reset mid-block discards the block; no done_o or err_o is emitted after release.

Configuration
REQ-031 Macro AES_ROUND_CTRL_TIMEOUT_EN: when defined, a wait counter clears on entry to KEY_REQ/SUB/MIX and increments each cycle; reaching TIMEOUT_CYCLES moves the FSM to ERR (err_o=1 for one cycle), then IDLE.
REQ-032 Without AES_ROUND_CTRL_TIMEOUT_EN: no counter is present, the FSM waits indefinitely, and err_o is tied to 0.

Structure
REQ-033 Package aes_pkg holds the state enum typedef aes_round_state_e and the constants AES128_NUM_ROUNDS=10 and AES256_NUM_ROUNDS=14.
REQ-034 The watchdog is the sub-module aes_wait_timer (clear, enable, expire), instantiated only under the macro; the rest is flat.

Verification
REQ-035 Reset, then start_i pulse with key_vld_i, sub_done_i, and mix_done_i tied high -> done_o 51 edges after start; ark_en_o count 11; mix_en_o count 9; key_sel_o sequence 0..10.
REQ-036 key_vld_i delayed 3 cycles in round 4 -> key_req_o held 4 cycles with key_sel_o=4 stable; done_o at edge 54.
REQ-037 abort_i asserted during MIX of round 5 -> IDLE next cycle, busy_o=0, no done_o; a following start_i runs a full block normally.
REQ-038 With macro defined and TIMEOUT_CYCLES=8, sub_done_i held low -> err_o pulse after 8 SUB cycles, then IDLE; without the macro, sub_en_o stays high indefinitely.
REQ-039 resetn pulsed low during round 7 -> all outputs 0 immediately; no done_o after release.
REQ-040 start_i held high continuously -> back-to-back blocks with exactly one IDLE cycle between done_o and the next key_req_o.
